// File: rtl/ssp_seq_pkg.sv
// ============================================================================
// Module      : ssp_seq_pkg
// Description : Shared constants and state encoding for the SSP host
//               sequencer (frame length, data width, data window start).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ssp_seq_pkg;

  // Frame geometry: 16 SCK periods per frame, 12-bit data, data phase
  // (SSP_En) starting at period 4.
  localparam int SSP_FRAME_BITS = 16;
  localparam int SSP_DATA_BITS  = 12;
  localparam int SSP_DATA_START = 4;

  // Sequencer state encoding.
  typedef logic [1:0] ssp_state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEL   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_END   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ssp_rr_arb.sv
// ============================================================================
// Module      : ssp_rr_arb
// Description : Two-way round-robin arbiter. When both requesters are
//               active, the one not granted last wins; out of reset A wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssp_rr_arb (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // High when B was granted last, i.e. A is next in line on a tie.
  logic last_b_q;

  // Combinational one-hot grant, only while the host can accept a frame.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_b_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  // Remember the last winner; reset leaves A as next.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_b_q <= 1'b1;
    end else if (|gnt_o) begin
      last_b_q <= gnt_o[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ssp_host_seq.sv
// ============================================================================
// Module      : ssp_host_seq
// Description : Arbitrates two requesters and runs one 16-period SSP frame
//               (IDLE -> SEL -> SHIFT -> END) per grant against an SSP_UART
//               slave. Reads capture SSP_DO at the last clock of the frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssp_host_seq
  import ssp_seq_pkg::*;
#(
  parameter int SCK_HALF = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [1:0]                    req_i,
  input  logic [1:0][2:0]               req_ra_i,
  input  logic [1:0]                    req_wnr_i,
  input  logic [1:0][SSP_DATA_BITS-1:0] req_wd_i,
  output logic [1:0]                    gnt_o,
  output logic [1:0]                    done_o,
  output logic [SSP_DATA_BITS-1:0]      rd_o,
  output logic                          ssp_ssel_o,
  output logic                          ssp_sck_o,
  output logic                          ssp_wnr_o,
  output logic                          ssp_en_o,
  output logic                          ssp_eoc_o,
  output logic [2:0]                    ssp_ra_o,
  output logic [SSP_DATA_BITS-1:0]      ssp_di_o,
  input  logic [SSP_DATA_BITS-1:0]      ssp_do_i,
  output logic                          busy_o
);

  localparam logic [3:0] HALF_LAST   = 4'(SCK_HALF - 1);
  localparam logic [3:0] PERIOD_LAST = 4'(SSP_FRAME_BITS - 1);
  localparam logic [3:0] DATA_FIRST  = 4'(SSP_DATA_START);

  ssp_state_t               state_q, state_d;
  logic [3:0]               half_q, half_d;
  logic [3:0]               period_q, period_d;
  logic                     phase_q, phase_d;
  logic [1:0]               owner_q;
  logic [2:0]               ra_q;
  logic                     wnr_q;
  logic [SSP_DATA_BITS-1:0] wd_q;
  logic [SSP_DATA_BITS-1:0] rd_q;
  logic [1:0]               arb_gnt;
  logic                     arb_en;
  logic                     half_end;
  logic                     frame_last;

  // Grants are only offered in IDLE and never while reset is asserted.
  assign arb_en = rst_ni && (state_q == ST_IDLE);

  ssp_rr_arb u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .en_i   (arb_en),
    .gnt_o  (arb_gnt)
  );

  assign half_end   = (half_q == HALF_LAST);
  assign frame_last = (state_q == ST_SHIFT) && (period_q == PERIOD_LAST) &&
                      phase_q && half_end;

  // Next-state logic for the FSM and the SCK half/period counters.
  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    period_d = period_q;
    phase_d  = phase_q;
    case (state_q)
      ST_IDLE: begin
        half_d   = 4'd0;
        period_d = 4'd0;
        phase_d  = 1'b0;
        if (|arb_gnt) state_d = ST_SEL;
      end
      ST_SEL: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (half_end) begin
          half_d = 4'd0;
          if (phase_q) begin
            phase_d  = 1'b0;
            period_d = period_q + 4'd1;
            if (period_q == PERIOD_LAST) state_d = ST_END;
          end else begin
            phase_d = 1'b1;
          end
        end else begin
          half_d = half_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      half_q   <= 4'd0;
      period_q <= 4'd0;
      phase_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      period_q <= period_d;
      phase_q  <= phase_d;
    end
  end

  // Capture the winner's command at grant; later Req changes are ignored.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      owner_q <= 2'b00;
      ra_q    <= 3'd0;
      wnr_q   <= 1'b0;
      wd_q    <= '0;
    end else if (|arb_gnt) begin
      owner_q <= arb_gnt;
      ra_q    <= req_ra_i[arb_gnt[1]];
      wnr_q   <= req_wnr_i[arb_gnt[1]];
      wd_q    <= req_wd_i[arb_gnt[1]];
    end
  end

  // Read data is sampled on the final clock of the frame; writes leave it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q <= '0;
    end else if (frame_last && !wnr_q) begin
      rd_q <= ssp_do_i;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign gnt_o      = arb_gnt;
  assign done_o     = (state_q == ST_END) ? owner_q : 2'b00;
  assign rd_o       = rd_q;
  assign ssp_ssel_o = (state_q == ST_SEL) || (state_q == ST_SHIFT);
  assign ssp_sck_o  = (state_q == ST_SHIFT) && phase_q;
  assign ssp_en_o   = (state_q == ST_SHIFT) && (period_q >= DATA_FIRST);
  assign ssp_eoc_o  = (state_q == ST_SHIFT) && (period_q == PERIOD_LAST);
  assign ssp_wnr_o  = busy_o && wnr_q;
  assign ssp_ra_o   = busy_o ? ra_q : 3'd0;
  assign ssp_di_o   = busy_o ? wd_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_ssp_host_seq.sv
// ============================================================================
// Module      : tb_ssp_host_seq
// Description : Directed bench for ssp_host_seq (SCK_HALF=2 and SCK_HALF=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ssp_host_seq;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req;
  logic [1:0][2:0]  ra;
  logic [1:0]       wnr;
  logic [1:0][11:0] wd;
  logic [1:0]       gnt, done;
  logic [11:0]      rd, di, sdo;
  logic             ssel, sck, swnr, sen, eoc, busy;
  logic [2:0]       sra;

  logic [1:0]       req1;
  logic [1:0][2:0]  ra1;
  logic [1:0]       wnr1;
  logic [1:0][11:0] wd1;
  logic [1:0]       gnt1, done1;
  logic [11:0]      rd1, di1;
  logic             ssel1, sck1, swnr1, sen1, eoc1, busy1;
  logic [2:0]       sra1;

  int total = 0;
  int bad   = 0;

  int         m_done_at, m_gnt_at, m_en, m_eoc, m_both, m_fld_bad;
  logic [1:0] m_done_val, m_gnt_val;
  logic [11:0] m_rd;

  ssp_host_seq #(.SCK_HALF(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_ra_i(ra), .req_wnr_i(wnr),
    .req_wd_i(wd), .gnt_o(gnt), .done_o(done), .rd_o(rd), .ssp_ssel_o(ssel),
    .ssp_sck_o(sck), .ssp_wnr_o(swnr), .ssp_en_o(sen), .ssp_eoc_o(eoc),
    .ssp_ra_o(sra), .ssp_di_o(di), .ssp_do_i(sdo), .busy_o(busy)
  );

  ssp_host_seq #(.SCK_HALF(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .req_ra_i(ra1), .req_wnr_i(wnr1),
    .req_wd_i(wd1), .gnt_o(gnt1), .done_o(done1), .rd_o(rd1), .ssp_ssel_o(ssel1),
    .ssp_sck_o(sck1), .ssp_wnr_o(swnr1), .ssp_en_o(sen1), .ssp_eoc_o(eoc1),
    .ssp_ra_o(sra1), .ssp_di_o(di1), .ssp_do_i(12'h000), .busy_o(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps n cycles after a Gnt cycle and records what the frame did.
  task automatic measure(input int n, input bit drop, input logic [2:0] exp_ra,
                         input logic [11:0] exp_di, input logic exp_wnr);
    m_done_at = -1; m_gnt_at = -1; m_en = 0; m_eoc = 0; m_both = 0; m_fld_bad = 0;
    m_done_val = 2'b00; m_gnt_val = 2'b00; m_rd = 12'h000;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (done !== 2'b00 && m_done_at < 0) begin
        m_done_at = k; m_done_val = done; m_rd = rd;
      end
      if (gnt !== 2'b00 && m_gnt_at < 0) begin
        m_gnt_at = k; m_gnt_val = gnt;
      end
      if (gnt !== 2'b00 && done !== 2'b00) m_both++;
      m_en  += int'(sen);
      m_eoc += int'(eoc);
      if (busy && (sra !== exp_ra || di !== exp_di || swnr !== exp_wnr)) m_fld_bad++;
      if (k == 1 && drop) req = 2'b00;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({gnt, done, rd, ssel, sck, swnr, sen, eoc, sra, di, busy} !== '0) begin
      bad++; $display("FAIL reset_outputs: got nonzero outputs busy=%b ssel=%b rd=%h", busy, ssel, rd);
    end
    rst_n = 1'b1;
    tick();
    req = 2'b11;
    #1;
    total++;
    if (gnt !== 2'b01) begin
      bad++; $display("FAIL reset_priority: got %b want 01", gnt);
    end
    req = 2'b00;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL withdrawn_req_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_write_a();
    ra[0] = 3'd3; wnr[0] = 1'b1; wd[0] = 12'hA5C;
    req = 2'b01;
    #1;
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL write_gnt: got %b want 01", gnt); end
    measure(67, 1'b1, 3'd3, 12'hA5C, 1'b1);
    total++;
    if (m_done_at != 66) begin bad++; $display("FAIL write_done_at: got %0d want 66", m_done_at); end
    total++;
    if (m_done_val !== 2'b01) begin bad++; $display("FAIL write_done_val: got %b want 01", m_done_val); end
    total++;
    if (m_en != 48) begin bad++; $display("FAIL write_en_cycles: got %0d want 48", m_en); end
    total++;
    if (m_eoc != 4) begin bad++; $display("FAIL write_eoc_cycles: got %0d want 4", m_eoc); end
    total++;
    if (m_fld_bad != 0) begin bad++; $display("FAIL write_fields: got %0d bad cycles want 0", m_fld_bad); end
    total++;
    if (m_both != 0) begin bad++; $display("FAIL write_gnt_done_overlap: got %0d want 0", m_both); end
    total++;
    if (rd !== 12'h000) begin bad++; $display("FAIL write_rd_hold: got %h want 000", rd); end
    total++;
    if ({busy, ssel} !== 2'b00) begin bad++; $display("FAIL write_after_end: got busy,ssel=%b want 00", {busy, ssel}); end
  endtask

  task automatic test_read_b();
    ra[1] = 3'd5; wnr[1] = 1'b0; wd[1] = 12'h000; sdo = 12'h3F1;
    req = 2'b10;
    #1;
    total++;
    if (gnt !== 2'b10) begin bad++; $display("FAIL read_gnt: got %b want 10", gnt); end
    measure(67, 1'b1, 3'd5, 12'h000, 1'b0);
    total++;
    if (m_done_at != 66 || m_done_val !== 2'b10) begin
      bad++; $display("FAIL read_done: got at=%0d val=%b want at=66 val=10", m_done_at, m_done_val);
    end
    total++;
    if (m_rd !== 12'h3F1) begin bad++; $display("FAIL read_rd_at_done: got %h want 3F1", m_rd); end
    total++;
    if (m_fld_bad != 0) begin bad++; $display("FAIL read_fields_wnr: got %0d bad cycles want 0", m_fld_bad); end
    sdo = 12'h000;
    tick();
    total++;
    if (rd !== 12'h3F1) begin bad++; $display("FAIL read_rd_hold: got %h want 3F1", rd); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    ra[0] = 3'd1; wnr[0] = 1'b1; wd[0] = 12'h111;
    ra[1] = 3'd6; wnr[1] = 1'b1; wd[1] = 12'h222;
    req = 2'b11;
    #1;
    for (int f = 0; f < 4; f++) begin
      exp_g = (f % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if (gnt !== exp_g || busy !== 1'b0) begin
        bad++; $display("FAIL rr_gnt%0d: got gnt=%b busy=%b want gnt=%b busy=0", f, gnt, busy, exp_g);
      end
      measure(67, f == 3, exp_g[1] ? 3'd6 : 3'd1, exp_g[1] ? 12'h222 : 12'h111, 1'b1);
      total++;
      if (m_done_at != 66 || m_done_val !== exp_g || m_both != 0) begin
        bad++; $display("FAIL rr_done%0d: got at=%0d val=%b both=%0d want at=66 val=%b both=0",
                        f, m_done_at, m_done_val, m_both, exp_g);
      end
      if (f < 3) begin
        total++;
        if (m_gnt_at != 67) begin bad++; $display("FAIL rr_gap%0d: next gnt at %0d want 67", f, m_gnt_at); end
      end
    end
    total++;
    if (rd !== 12'h3F1) begin bad++; $display("FAIL rr_rd_hold: got %h want 3F1", rd); end
  endtask

  task automatic test_abort();
    int done_seen;
    done_seen = 0;
    ra[0] = 3'd2; wnr[0] = 1'b1; wd[0] = 12'h0F0;
    req = 2'b01;
    #1;
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL abort_gnt: got %b want 01", gnt); end
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (done !== 2'b00) done_seen++;
    end
    rst_n = 1'b0;
    tick();
    if (done !== 2'b00) done_seen++;
    total++;
    if ({gnt, done, rd, ssel, sck, swnr, sen, eoc, sra, di, busy} !== '0) begin
      bad++; $display("FAIL abort_outputs: got busy=%b ssel=%b sck=%b en=%b rd=%h want all 0",
                      busy, ssel, sck, sen, rd);
    end
    total++;
    if (done_seen != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", done_seen); end
    rst_n = 1'b1;
    req = 2'b11;
    #1;
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL abort_regrant: got %b want 01", gnt); end
    measure(67, 1'b1, 3'd2, 12'h0F0, 1'b1);
    total++;
    if (m_done_at != 66 || m_done_val !== 2'b01) begin
      bad++; $display("FAIL abort_regrant_done: got at=%0d val=%b want at=66 val=01", m_done_at, m_done_val);
    end
  endtask

  task automatic test_fast_sck();
    int done_at, sck_bad, both;
    done_at = -1; sck_bad = 0; both = 0;
    ra1[0] = 3'd4; wnr1[0] = 1'b1; wd1[0] = 12'h5A5;
    req1 = 2'b01;
    #1;
    total++;
    if (gnt1 !== 2'b01) begin bad++; $display("FAIL fast_gnt: got %b want 01", gnt1); end
    for (int k = 1; k <= 36; k++) begin
      tick();
      if (k == 1) req1 = 2'b00;
      if (done1 !== 2'b00 && done_at < 0) done_at = k;
      if (gnt1 !== 2'b00 && done1 !== 2'b00) both++;
      if (k >= 2 && k <= 33 && sck1 !== k[0]) sck_bad++;
    end
    total++;
    if (done_at != 34) begin bad++; $display("FAIL fast_done_at: got %0d want 34", done_at); end
    total++;
    if (sck_bad != 0 || both != 0) begin
      bad++; $display("FAIL fast_sck_toggle: got %0d bad sck cycles, %0d overlaps want 0", sck_bad, both);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; ra = '0; wnr = '0; wd = '0; sdo = 12'h000;
    req1 = 2'b00; ra1 = '0; wnr1 = '0; wd1 = '0;
    test_reset();
    test_write_a();
    test_read_b();
    test_round_robin();
    test_abort();
    test_fast_sck();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ssp_host_seq.md
SSP_HOST_SEQ -- requirements
Module: ssp_host_seq

Interface
REQ-001 Parameter SCK_HALF, default 2, Clk cycles per SSP_SCK half-period (legal range 1..15).
REQ-002 Clk  input  1  system clock; all logic rising-edge.
REQ-003 Rst_n  input  1  synchronous active-low reset.
REQ-004 Req  input  2  per-requester access request; index 0 = requester A, index 1 = requester B.
REQ-005 Req_RA  input  2x3  per-requester SSP register address.
REQ-006 Req_WnR  input  2  per-requester command: 1 = write, 0 = read.
REQ-007 Req_WD  input  2x12  per-requester write data.
REQ-008 Gnt  output  2  one-cycle acceptance pulse, one-hot.
REQ-009 Done  output  2  one-cycle completion pulse, one-hot, to the granted requester.
REQ-010 RD  output  12  read data, valid while Done is high.
REQ-011 SSP_SSEL, SSP_SCK, SSP_WnR, SSP_En, SSP_EOC  output  1 each  SSP_UART slave controls.
REQ-012 SSP_RA  output  3;  SSP_DI  output  12  SSP_UART address and write data.
REQ-013 SSP_DO  input  12  SSP_UART read data.
REQ-014 Busy  output  1  high from the SEL cycle through the END cycle.

Function
REQ-015 FSM states: IDLE, SEL, SHIFT, END.
REQ-016 IDLE: if any Req is set, the arbiter picks one, Gnt pulses for 1 cycle, {RA,WnR,WD} are latched, and the FSM goes to SEL; otherwise it stays in IDLE.
REQ-017 Arbitration is round-robin: when both Req bits are set, the requester not granted last wins; after reset, A has priority.
REQ-018 A requester holds Req and its fields stable until Gnt; fields are ignored after Gnt.
REQ-019 SEL lasts 1 cycle: SSP_SSEL=1, SSP_RA/SSP_WnR/SSP_DI are driven from latched values and held through END.
REQ-020 SHIFT runs 16 SCK periods, each 2*SCK_HALF Clk cycles: SSP_SCK low for the first half, high for the second half.
REQ-021 A 4-bit period counter counts 0..15; SSP_En=1 for periods 4..15; SSP_EOC=1 for period 15 only.
REQ-022 Read: RD is loaded from SSP_DO on the last Clk of period 15. Write: RD holds its previous value.
REQ-023 END lasts 1 cycle: SSP_SSEL=0, SSP_SCK=0, SSP_En=0, SSP_EOC=0, and Done pulses for the granted requester. The next cycle is IDLE.
REQ-024 Latency: Gnt at cycle t, SEL at t+1, SHIFT at t+2..t+1+32*SCK_HALF, Done at t+2+32*SCK_HALF (t+66 for the default).
REQ-025 A new Gnt is possible no earlier than the cycle after END (minimum 1 IDLE cycle between frames).
REQ-026 Req changes during SEL/SHIFT/END do not affect the active frame; pending requests are arbitrated in the next IDLE.
REQ-027 Gnt and Done are never both high in the same cycle.

Reset
REQ-028 Rst_n=0 at any edge, including mid-frame: the next state is IDLE.
REQ-029 On reset, all SSP_* outputs, Gnt, Done, Busy and RD are 0, the period and half counters are 0, and the round-robin pointer is "A next".
REQ-030 An aborted frame produces no Done pulse.

Structure
REQ-031 Package ssp_seq_pkg holds the state enum plus SSP_FRAME_BITS=16, SSP_DATA_BITS=12 and SSP_DATA_START=4.
REQ-032 Sub-module ssp_rr_arb: 2-way round-robin arbiter with inputs req[1:0] and en, output gnt[1:0] one-hot, and an internal last-grant flop.

Verification
REQ-033 A writes RA=3, WD=12'hA5C, default SCK_HALF -> Gnt[0] at t; SSP_DI=12'hA5C and SSP_RA=3 from t+1; SSP_En high for 48 cycles; SSP_EOC high for 4 cycles; Done[0] at t+66.
REQ-034 B reads RA=5 with SSP_DO=12'h3F1 -> RD=12'h3F1 with Done[1]; SSP_WnR=0 for the whole frame.
REQ-035 A and B request together, continuously, for 4 frames -> grant order A,B,A,B; IDLE gap of exactly 1 cycle between frames.
REQ-036 Rst_n low for 1 cycle at SCK period 7 -> outputs 0 next cycle, no Done, FSM idle; a request held by A is re-granted after reset release.
REQ-037 SCK_HALF=1 -> SSP_SCK toggles every cycle; Done at t+34.
REQ-038 Gnt and Done are never both high in the same cycle (REQ-027).
